// File: rtl/siso_pkg.sv
// Shared definitions for the SISO shift-register link controller and its chain model.
package siso_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } siso_ctrl_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/siso_chain.sv
// DEPTH-stage serial-in serial-out shift chain with no enable and no reset.
module siso_chain #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic b,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    sr[0] <= b;
    for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/siso_link_ctrl.sv
// Sends a parallel word bit-serially through an external SISO chain and reassembles
// the returning bits, flagging whether the received word matches what was sent.
module siso_link_ctrl
  import siso_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             b,
  input  logic             q,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_match,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] W_C  = CW'(WIDTH);
  localparam logic [CW-1:0] D_C  = CW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH + DEPTH - 1);

  siso_ctrl_state_t state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    nxt;
  logic [WIDTH-1:0] tx_word;

  function automatic logic [IW-1:0] idx(input logic [CW-1:0] i);
    int unsigned v;
    v = (LSB_FIRST != 0) ? 32'(i) : 32'(WIDTH - 1) - 32'(i);
    return IW'(v);
  endfunction

  assign nxt      = cnt + CW'(1);
  assign tx_ready = (state == IDLE) && !rst;
  assign rx_match = (state == DONE) && (rx_data == tx_word);

  // b is registered one step ahead so the bit for cycle cnt is on the wire during that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_word  <= '0;
      rx_data  <= '0;
      b        <= 1'b0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_word <= tx_data;
            cnt     <= '0;
            rx_data <= '0;
            b       <= tx_data[idx(CW'(0))];
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (cnt >= D_C) rx_data[idx(cnt - D_C)] <= q;
          if (cnt == LAST) begin
            b        <= 1'b0;
            rx_valid <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= nxt;
            b   <= (nxt < W_C) ? tx_word[idx(nxt)] : 1'b0;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_siso_link_ctrl.sv
// Scoreboard bench for siso_link_ctrl driving real behavioural SISO chains.
module tb_siso_link_ctrl;

  typedef struct {
    logic [7:0] data;
    logic       match;
  } exp_t;

  logic clk, rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   pulses0 = 0, pulses1 = 0, pulses2 = 0;
  exp_t sb0[$], sb1[$], sb2[$];

  // instance 0: WIDTH=8 DEPTH=4 LSB-first, with optional q inversion
  logic [7:0] tx_data0, rx_data0;
  logic tx_valid0, tx_ready0, b0, cq0, q0, rx_valid0, rx_match0, busy0, inv0;
  // instance 1: WIDTH=8 DEPTH=4 MSB-first
  logic [7:0] tx_data1, rx_data1;
  logic tx_valid1, tx_ready1, b1, q1, rx_valid1, rx_match1, busy1;
  // instance 2: WIDTH=1 DEPTH=1
  logic [0:0] tx_data2, rx_data2;
  logic tx_valid2, tx_ready2, b2, q2, rx_valid2, rx_match2, busy2;

  assign q0 = cq0 ^ inv0;

  siso_link_ctrl #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .b(b0), .q(q0), .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_match(rx_match0), .busy(busy0));
  siso_chain #(.DEPTH(4)) c0 (.clk(clk), .b(b0), .q(cq0));

  siso_link_ctrl #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(0)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .b(b1), .q(q1), .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_match(rx_match1), .busy(busy1));
  siso_chain #(.DEPTH(4)) c1 (.clk(clk), .b(b1), .q(q1));

  siso_link_ctrl #(.WIDTH(1), .DEPTH(1), .LSB_FIRST(1)) u2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .b(b2), .q(q2), .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_match(rx_match2), .busy(busy2));
  siso_chain #(.DEPTH(1)) c2 (.clk(clk), .b(b2), .q(q2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: rx_valid with empty scoreboard, got 1, expected 0 (cycle %0d)", name, cyc);
  endtask

  // Monitors: pop the scoreboard whenever a word is presented
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rx_valid0) begin
      pulses0++;
      if (sb0.size() == 0) unexpected("mon0");
      else begin
        e = sb0.pop_front();
        check("mon0_rx_data", 32'(rx_data0), 32'(e.data));
        check("mon0_rx_match", 32'(rx_match0), 32'(e.match));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rx_valid1) begin
      pulses1++;
      if (sb1.size() == 0) unexpected("mon1");
      else begin
        e = sb1.pop_front();
        check("mon1_rx_data", 32'(rx_data1), 32'(e.data));
        check("mon1_rx_match", 32'(rx_match1), 32'(e.match));
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rx_valid2) begin
      pulses2++;
      if (sb2.size() == 0) unexpected("mon2");
      else begin
        e = sb2.pop_front();
        check("mon2_rx_data", 32'(rx_data2), 32'(e.data));
        check("mon2_rx_match", 32'(rx_match2), 32'(e.match));
      end
    end
  end

  // Called just after a negedge in IDLE; returns at the negedge of RUN cycle 1.
  task automatic send0(input logic [7:0] d, input bit push, input logic [7:0] exp_d,
                       input logic exp_m);
    check("send0_ready", 32'(tx_ready0), 32'd1);
    tx_data0  = d;
    tx_valid0 = 1'b1;
    if (push) sb0.push_back('{exp_d, exp_m});
    @(posedge clk);
    @(negedge clk);
    tx_valid0 = 1'b0;
  endtask

  // Bounded wait for an instance-1 accept; returns the cycle stamp of the accept.
  task automatic accept1(output int stamp);
    bit ok = 1'b0;
    stamp = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (tx_ready1) begin
        @(posedge clk);
        @(negedge clk);
        stamp = cyc;
        ok    = 1'b1;
      end else @(negedge clk);
    end
    if (!ok) check("accept1_timeout", 32'd0, 32'd1);
  endtask

  logic [11:0] bseq;
  int p_before, a1, a2;

  initial begin
    rst = 1'b1;
    inv0 = 1'b0;
    tx_data0 = '0; tx_valid0 = 1'b0;
    tx_data1 = '0; tx_valid1 = 1'b0;
    tx_data2 = '0; tx_valid2 = 1'b0;
    bseq = 12'b0000_1010_0101;   // bit k = expected b in RUN cycle k+1 for 0xA5

    // reset state
    repeat (3) @(negedge clk);
    check("rst_b", 32'(b0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_rx_valid", 32'(rx_valid0), 32'd0);
    check("rst_rx_match", 32'(rx_match0), 32'd0);
    check("rst_rx_data", 32'(rx_data0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready0), 32'd1);

    // single word 0xA5, LSB first
    send0(8'hA5, 1'b1, 8'hA5, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("single_b_c%0d", k), 32'(b0), 32'(bseq[k-1]));
      if (k == 1 || k == 12) begin
        check($sformatf("single_busy_c%0d", k), 32'(busy0), 32'd1);
        check($sformatf("single_rx_valid_c%0d", k), 32'(rx_valid0), 32'd0);
      end
    end
    @(negedge clk);
    check("single_rx_valid_c13", 32'(rx_valid0), 32'd1);
    check("single_busy_c13", 32'(busy0), 32'd1);
    @(negedge clk);
    check("single_rx_valid_c14", 32'(rx_valid0), 32'd0);
    check("single_rx_match_c14", 32'(rx_match0), 32'd0);
    check("single_hold_rx_data", 32'(rx_data0), 32'hA5);
    check("single_ready_c14", 32'(tx_ready0), 32'd1);

    // fault injection: inverted return path
    inv0 = 1'b1;
    p_before = pulses0;
    send0(8'hA5, 1'b1, 8'h5A, 1'b0);
    repeat (14) @(negedge clk);
    check("fault_pulses", 32'(pulses0 - p_before), 32'd1);
    inv0 = 1'b0;

    // requests during RUN are ignored
    p_before = pulses0;
    send0(8'h12, 1'b1, 8'h12, 1'b1);
    tx_data0 = 8'hFF;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      tx_valid0 = k[0];
      check($sformatf("ignore_ready_c%0d", k), 32'(tx_ready0), 32'd0);
    end
    @(negedge clk);
    tx_valid0 = 1'b0;
    repeat (4) @(negedge clk);
    check("ignore_pulses", 32'(pulses0 - p_before), 32'd1);
    check("ignore_idle_busy", 32'(busy0), 32'd0);

    // reset at cnt=6 of a 0xFF transfer, then 0x00 through a chain full of 1s
    p_before = pulses0;
    send0(8'hFF, 1'b0, 8'h00, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_b", 32'(b0), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_rx_data", 32'(rx_data0), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("midrst_b_held", 32'(b0), 32'd0);
    check("midrst_busy_held", 32'(busy0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(tx_ready0), 32'd1);
    send0(8'h00, 1'b1, 8'h00, 1'b1);
    repeat (14) @(negedge clk);
    check("midrst_pulses", 32'(pulses0 - p_before), 32'd1);

    // MSB first, back-to-back with tx_valid held
    tx_data1  = 8'h81;
    tx_valid1 = 1'b1;
    sb1.push_back('{8'h81, 1'b1});
    accept1(a1);
    tx_data1 = 8'h3C;
    sb1.push_back('{8'h3C, 1'b1});
    accept1(a2);
    tx_valid1 = 1'b0;
    check("msb_spacing", 32'(a2 - a1), 32'd14);
    repeat (15) @(negedge clk);
    check("msb_pulses", 32'(pulses1), 32'd2);

    // minimum configuration WIDTH=1 DEPTH=1
    tx_data2  = 1'b1;
    tx_valid2 = 1'b1;
    sb2.push_back('{8'h01, 1'b1});
    @(posedge clk);
    @(negedge clk);
    tx_valid2 = 1'b0;
    check("min_b_c1", 32'(b2), 32'd1);
    check("min_busy_c1", 32'(busy2), 32'd1);
    @(negedge clk);
    check("min_b_c2", 32'(b2), 32'd0);
    check("min_rx_valid_c2", 32'(rx_valid2), 32'd0);
    @(negedge clk);
    check("min_rx_valid_c3", 32'(rx_valid2), 32'd1);
    @(negedge clk);
    check("min_rx_valid_c4", 32'(rx_valid2), 32'd0);
    check("min_rx_data_hold", 32'(rx_data2), 32'd1);

    check("sb0_empty", 32'(sb0.size()), 32'd0);
    check("sb1_empty", 32'(sb1.size()), 32'd0);
    check("sb2_empty", 32'(sb2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
